// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB initiator bridging single host commands onto an 8-bit register bus
//
// Ports:
//   PCLK_i, PRESET_N_i                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o          host command handshake (ready only in IDLE)
//   cmd_write_i, cmd_addr_i, cmd_wdata_i  command fields, latched on acceptance
//   rsp_valid_o                        one-cycle completion strobe
//   rsp_rdata_o                        read data (0 after a write or a timeout), held between responses
//   rsp_timeout_o                      qualifies rsp_valid_o: transfer aborted
//   PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o  APB request outputs (all registered)
//   PRDATA_i, PREADY_i                 APB completer response
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK_i,
    input  logic                  PRESET_N_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_timeout_o,
    output logic                  PSEL_o,
    output logic                  PENABLE_o,
    output logic                  PWRITE_o,
    output logic [ADDR_WIDTH-1:0] PADDR_o,
    output logic [DATA_WIDTH-1:0] PWDATA_o,
    input  logic [DATA_WIDTH-1:0] PRDATA_i,
    input  logic                  PREADY_i
);

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
    // Counter value seen on the edge that is the final permitted wait edge.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_d, rsp_valid_d, rsp_timeout_d;
    logic                  psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d, rdata_d;

    always_ff @(posedge PCLK_i or negedge PRESET_N_i) begin
        if (!PRESET_N_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= '0;
            PSEL_o        <= 1'b0;
            PENABLE_o     <= 1'b0;
            PWRITE_o      <= 1'b0;
            PADDR_o       <= '0;
            PWDATA_o      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_o   <= ready_d;
            rsp_valid_o   <= rsp_valid_d;
            rsp_timeout_o <= rsp_timeout_d;
            rsp_rdata_o   <= rdata_d;
            PSEL_o        <= psel_d;
            PENABLE_o     <= penable_d;
            PWRITE_o      <= pwrite_d;
            PADDR_o       <= paddr_d;
            PWDATA_o      <= pwdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ready_d       = cmd_ready_o;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rdata_d       = rsp_rdata_o;
        psel_d        = PSEL_o;
        penable_d     = PENABLE_o;
        pwrite_d      = PWRITE_o;
        paddr_d       = PADDR_o;
        pwdata_d      = PWDATA_o;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid_i) begin
                    pwrite_d  = cmd_write_i;
                    paddr_d   = cmd_addr_i;
                    pwdata_d  = cmd_wdata_i;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    ready_d   = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY wins over an expiring count on the same edge.
                if (PREADY_i) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    ready_d     = 1'b1;
                    rdata_d     = PWRITE_o ? '0 : PRDATA_i;
                    state_d     = ST_IDLE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    ready_d       = 1'b1;
                    rdata_d       = '0;
                    state_d       = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic       PCLK_i = 1'b0;
    logic       PRESET_N_i = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic       cmd_write_i = 1'b0;
    logic [7:0] cmd_addr_i = '0;
    logic [7:0] cmd_wdata_i = '0;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic       rsp_timeout_o;
    logic       PSEL_o, PENABLE_o, PWRITE_o;
    logic [7:0] PADDR_o, PWDATA_o;
    logic [7:0] PRDATA_i = '0;
    logic       PREADY_i = 1'b0;

    apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK_i(PCLK_i), .PRESET_N_i(PRESET_N_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
        .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o),
        .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
        .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i)
    );

    always #5 PCLK_i = ~PCLK_i;

    int n_pass = 0;
    int n_total = 0;

    // Reactive completer: holds PREADY low for cur_waits ACCESS cycles, then raises it.
    int         cur_waits = 0;
    logic [7:0] cur_prdata = '0;
    int         acc_cnt = 0;
    always @(negedge PCLK_i) begin
        if (PSEL_o && PENABLE_o) begin
            PREADY_i = (acc_cnt == cur_waits);
            acc_cnt  = acc_cnt + 1;
        end else begin
            PREADY_i = 1'b0;
            acc_cnt  = 0;
        end
        PRDATA_i = cur_prdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: a transfer that sees TO consecutive low-PREADY edges aborts on the last one;
    // otherwise it completes on the first high edge. Latency counts edges after the accept edge.
    task automatic model(input logic w, input int waits, input logic [7:0] prd,
                         output logic to, output logic [7:0] rd, output int lat);
        to  = (TO != 0) && (waits >= TO);
        lat = to ? (1 + TO) : (2 + waits);
        rd  = (to || w) ? 8'h00 : prd;
    endtask

    task automatic run_txn(input string name, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input int waits, input logic [7:0] prd,
                           input logic exp_to, input logic [7:0] exp_rd, input int exp_lat,
                           input bit hold_valid, input bit idle_after);
        int lat;
        cur_waits  = waits;
        cur_prdata = prd;
        chk({name, ".ready_pre"}, 64'(cmd_ready_o), 64'd1);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        @(posedge PCLK_i); #1;
        if (!hold_valid) begin
            cmd_valid_i = 1'b0;
            cmd_addr_i  = 8'($urandom);
            cmd_wdata_i = 8'($urandom);
            cmd_write_i = ~w;
        end
        chk({name, ".setup"}, 64'({PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o, PWRITE_o, PADDR_o, PWDATA_o}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, w, a, d}));
        @(posedge PCLK_i); #1;
        chk({name, ".access"}, 64'({PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o, PWRITE_o, PADDR_o, PWDATA_o}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, w, a, d}));
        lat = 1;
        while (!rsp_valid_o && lat < 60) begin
            @(posedge PCLK_i); #1;
            lat++;
            if (!rsp_valid_o)
                chk({name, ".wait"}, 64'({PSEL_o, PENABLE_o, cmd_ready_o, PWRITE_o, PADDR_o, PWDATA_o}),
                    64'({1'b1, 1'b1, 1'b0, w, a, d}));
        end
        cmd_valid_i = 1'b0;
        chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({name, ".rsp"}, 64'({rsp_valid_o, rsp_timeout_o, rsp_rdata_o, PSEL_o, PENABLE_o, cmd_ready_o}),
            64'({1'b1, exp_to, exp_rd, 1'b0, 1'b0, 1'b1}));
        if (idle_after) begin
            @(posedge PCLK_i); #1;
            chk({name, ".after"}, 64'({rsp_valid_o, rsp_timeout_o, rsp_rdata_o, PSEL_o}),
                64'({1'b0, 1'b0, exp_rd, 1'b0}));
        end
    endtask

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         waits;
        logic [7:0] prd;
        logic       exp_to;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       m_to;
        logic [7:0] m_rd;
        int         m_lat;

        vecs[0] = '{1'b1, 8'h04, 8'hA5, 0,  8'h99, 1'b0, 8'h00, 2};
        vecs[1] = '{1'b0, 8'h10, 8'h00, 2,  8'h3C, 1'b0, 8'h3C, 4};
        vecs[2] = '{1'b0, 8'h20, 8'h00, 16, 8'h77, 1'b1, 8'h00, 17};
        vecs[3] = '{1'b0, 8'h21, 8'h00, 15, 8'h5A, 1'b0, 8'h5A, 17};
        vecs[4] = '{1'b1, 8'h30, 8'hC3, 20, 8'h11, 1'b1, 8'h00, 17};
        vecs[5] = '{1'b0, 8'hFF, 8'h00, 0,  8'hFF, 1'b0, 8'hFF, 2};

        #12;
        chk("reset", 64'({PSEL_o, PENABLE_o, rsp_valid_o, rsp_timeout_o, cmd_ready_o, PWRITE_o, PADDR_o, PWDATA_o, rsp_rdata_o}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00}));
        @(posedge PCLK_i); #1;
        PRESET_N_i = 1'b1;
        @(posedge PCLK_i); #1;

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].waits,
                    vecs[i].prd, vecs[i].exp_to, vecs[i].exp_rd, vecs[i].exp_lat, 1'b0, 1'b1);

        // Back-to-back with cmd_valid held through the first transfer.
        run_txn("b2b0", 1'b1, 8'h01, 8'h11, 0, 8'h00, 1'b0, 8'h00, 2, 1'b1, 1'b0);
        run_txn("b2b1", 1'b0, 8'h02, 8'h00, 0, 8'h6E, 1'b0, 8'h6E, 2, 1'b0, 1'b1);

        // Reset mid-ACCESS with PREADY low.
        cur_waits   = 1000;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 8'h55;
        @(posedge PCLK_i); #1;
        cmd_valid_i = 1'b0;
        repeat (4) @(posedge PCLK_i);
        #1;
        PRESET_N_i = 1'b0;
        #1;
        chk("rst_mid", 64'({PSEL_o, PENABLE_o, rsp_valid_o, rsp_timeout_o, cmd_ready_o, PWRITE_o, PADDR_o, PWDATA_o, rsp_rdata_o}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00}));
        @(posedge PCLK_i); #1;
        PRESET_N_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge PCLK_i); #1;
            chk("rst_nopulse", 64'({rsp_valid_o, PSEL_o, cmd_ready_o}), 64'({1'b0, 1'b0, 1'b1}));
        end
        run_txn("post_rst", 1'b1, 8'h04, 8'h5A, 1, 8'h00, 1'b0, 8'h00, 3, 1'b0, 1'b1);

        // Randomized transfers against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic       w;
            logic [7:0] a, d, prd;
            int         waits;
            w   = 1'($urandom);
            a   = 8'($urandom);
            d   = 8'($urandom);
            prd = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       waits = 0;
                1:       waits = $urandom_range(1, 4);
                2:       waits = $urandom_range(TO - 2, TO + 2);
                default: waits = $urandom_range(0, TO + 4);
            endcase
            model(w, waits, prd, m_to, m_rd, m_lat);
            run_txn($sformatf("rnd%0d", i), w, a, d, waits, prd, m_to, m_rd, m_lat,
                    1'($urandom), 1'($urandom));
        end
        @(posedge PCLK_i); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
